// File: rtl/alu_arbiter_if.sv
// Requester-side channel of alu_arbiter: operation handshake plus response handshake.
// The master modport is the requester and the slave modport is the arbiter.
interface alu_arbiter_if #(
  parameter int WIDTH = 6
);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_ctrl;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_carry;
  logic             rsp_zero;

  modport master (
    output req_valid, req_ctrl, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_carry, rsp_zero
  );

  modport slave (
    input  req_valid, req_ctrl, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_carry, rsp_zero
  );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters, one operation in flight at a time.
// Define ALU_ARB_FIXED_PRIO_EN for strict req0 priority instead of round-robin.
module alu_arbiter #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  alu_arbiter_if.slave     port0,
  alu_arbiter_if.slave     port1,
  output logic [3:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  input  logic             alu_zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             owner;
  logic [3:0]       op_ctrl;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res0_data;
  logic             res0_carry;
  logic             res0_zero;
  logic [WIDTH-1:0] res1_data;
  logic             res1_carry;
  logic             res1_zero;
  logic             grant_any;
  logic             grant_sel;
  logic             accept;
  logic             rsp_accept;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic             last_grant;
`endif

  // Ready is gated by rst so nothing can be accepted while reset is held.
  always_comb begin
    grant_any = port0.req_valid | port1.req_valid;
`ifdef ALU_ARB_FIXED_PRIO_EN
    grant_sel = ~port0.req_valid;
`else
    grant_sel = (port0.req_valid & port1.req_valid) ? ~last_grant : ~port0.req_valid;
`endif
    accept     = (state == IDLE) && grant_any && !rst;
    rsp_accept = owner ? port1.rsp_ready : port0.rsp_ready;
  end

  assign port0.req_ready = accept & ~grant_sel;
  assign port1.req_ready = accept & grant_sel;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   state_next = RESP;
      RESP:    if (rsp_accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner   <= 1'b0;
      op_ctrl <= '0;
      op_a    <= '0;
      op_b    <= '0;
    end else if (accept) begin
      owner   <= grant_sel;
      op_ctrl <= grant_sel ? port1.req_ctrl : port0.req_ctrl;
      op_a    <= grant_sel ? port1.req_a    : port0.req_a;
      op_b    <= grant_sel ? port1.req_b    : port0.req_b;
    end
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_grant <= 1'b1;
    else if (accept) last_grant <= grant_sel;
  end
`endif

  // Each requester keeps its own last result so an idle port never shows another's data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res0_data  <= '0;
      res0_carry <= 1'b0;
      res0_zero  <= 1'b0;
      res1_data  <= '0;
      res1_carry <= 1'b0;
      res1_zero  <= 1'b0;
    end else if (state == ISSUE) begin
      if (owner) begin
        res1_data  <= alu_out;
        res1_carry <= alu_carry;
        res1_zero  <= alu_zero;
      end else begin
        res0_data  <= alu_out;
        res0_carry <= alu_carry;
        res0_zero  <= alu_zero;
      end
    end
  end

  assign alu_ctrl = op_ctrl;
  assign alu_a    = op_a;
  assign alu_b    = op_b;

  assign port0.rsp_valid = (state == RESP) && !owner;
  assign port0.rsp_data  = res0_data;
  assign port0.rsp_carry = res0_carry;
  assign port0.rsp_zero  = res0_zero;

  assign port1.rsp_valid = (state == RESP) && owner;
  assign port1.rsp_data  = res1_data;
  assign port1.rsp_carry = res1_carry;
  assign port1.rsp_zero  = res1_zero;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter with a behavioural ALU and grant model.
// Honours ALU_ARB_FIXED_PRIO_EN for the expected grant order.
module tb_alu_arbiter;
  localparam int WIDTH = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] alu_ctrl;
  logic [5:0] alu_a;
  logic [5:0] alu_b;
  logic [5:0] alu_out;
  logic       alu_carry;
  logic       alu_zero;

  int   checks   = 0;
  int   failures = 0;
  logic model_last;

  alu_arbiter_if #(.WIDTH(WIDTH)) p0 ();
  alu_arbiter_if #(.WIDTH(WIDTH)) p1 ();

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .port0     (p0),
    .port1     (p1),
    .alu_ctrl  (alu_ctrl),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_out   (alu_out),
    .alu_carry (alu_carry),
    .alu_zero  (alu_zero)
  );

  always #5 clk = ~clk;

  // Returns {carry, zero, result}
  function automatic logic [7:0] alu_model(input logic [3:0] ctrl, input logic [5:0] a, input logic [5:0] b);
    logic [6:0] wide;
    logic [5:0] r;
    logic       c;
    c = 1'b0;
    wide = '0;
    case (ctrl)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin wide = {1'b0, a} + {1'b0, b}; r = wide[5:0]; c = wide[6]; end
      4'b0110: begin wide = {1'b0, a} - {1'b0, b}; r = wide[5:0]; c = wide[6]; end
      4'b1100: r = ~(a | b);
      default: r = a ^ b;
    endcase
    return {c, (r == 6'd0), r};
  endfunction

  function automatic logic [7:0] model_op(input logic [15:0] op);
    return alu_model(op[15:12], op[11:6], op[5:0]);
  endfunction

  function automatic logic [15:0] rand_op();
    logic [3:0] codes [6];
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b0111};
    return {codes[$urandom_range(0, 5)], 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63))};
  endfunction

  function automatic logic exp_grant(input logic v0, input logic v1);
`ifdef ALU_ARB_FIXED_PRIO_EN
    return v0 ? 1'b0 : 1'b1;
`else
    return (v0 && v1) ? ~model_last : (v0 ? 1'b0 : 1'b1);
`endif
  endfunction

  always_comb {alu_carry, alu_zero, alu_out} = alu_model(alu_ctrl, alu_a, alu_b);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    p0.req_valid = 1'b0; p1.req_valid = 1'b0;
    p0.rsp_ready = 1'b0; p1.rsp_ready = 1'b0;
    {p0.req_ctrl, p0.req_a, p0.req_b} = '0;
    {p1.req_ctrl, p1.req_a, p1.req_b} = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    @(negedge clk);
    rst = 1'b0;
    model_last = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    p0.req_valid = 1'b1;
    p1.req_valid = 1'b1;
    #2;
    checks++;
    if ({p0.req_ready, p1.req_ready} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL reset_ready: got %b expected 00", {p0.req_ready, p1.req_ready});
    end
    tick();
    checks++;
    if ({alu_ctrl, alu_a, alu_b} !== 16'h0) begin
      failures++;
      $display("[TB] FAIL reset_alu: got %h expected 0000", {alu_ctrl, alu_a, alu_b});
    end
    checks++;
    if ({p0.rsp_valid, p1.rsp_valid} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL reset_rsp_valid: got %b expected 00", {p0.rsp_valid, p1.rsp_valid});
    end
    checks++;
    if ({p0.rsp_carry, p0.rsp_zero, p0.rsp_data, p1.rsp_carry, p1.rsp_zero, p1.rsp_data} !== 16'h0) begin
      failures++;
      $display("[TB] FAIL reset_rsp_fields: got %h expected 0000",
               {p0.rsp_carry, p0.rsp_zero, p0.rsp_data, p1.rsp_carry, p1.rsp_zero, p1.rsp_data});
    end
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    model_last = 1'b1;
    tick();
  endtask

  task automatic test_single_op();
    p0.req_valid = 1'b1;
    {p0.req_ctrl, p0.req_a, p0.req_b} = {4'b0010, 6'd40, 6'd30};
    #1;
    checks++;
    if ({p0.req_ready, p1.req_ready} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL single_ready: got %b expected 10", {p0.req_ready, p1.req_ready});
    end
    model_last = 1'b0;
    tick();
    p0.req_valid = 1'b0;
    #1;
    checks++;
    if ({alu_ctrl, alu_a, alu_b} !== {4'b0010, 6'd40, 6'd30}) begin
      failures++;
      $display("[TB] FAIL single_issue_ops: got %h expected %h", {alu_ctrl, alu_a, alu_b}, {4'b0010, 6'd40, 6'd30});
    end
    checks++;
    if (p0.rsp_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_early_rsp: got %b expected 0", p0.rsp_valid);
    end
    tick();
    checks++;
    if ({p0.rsp_valid, p1.rsp_valid} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL single_rsp_valid: got %b expected 10", {p0.rsp_valid, p1.rsp_valid});
    end
    checks++;
    if ({p0.rsp_carry, p0.rsp_zero, p0.rsp_data} !== {1'b1, 1'b0, 6'd6}) begin
      failures++;
      $display("[TB] FAIL single_rsp_data: got %h expected %h", {p0.rsp_carry, p0.rsp_zero, p0.rsp_data}, {1'b1, 1'b0, 6'd6});
    end
    p0.rsp_ready = 1'b1;
    tick();
    p0.rsp_ready = 1'b0;
    checks++;
    if (p0.rsp_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_rsp_release: got %b expected 0", p0.rsp_valid);
    end
  endtask

  task automatic test_contention();
    logic        g_exp;
    logic [15:0] op0, op1, exp_ops;
    logic [7:0]  exp_rsp;
    logic [7:0]  got_rsp;
    int          hold;
    bit          got;
    do_reset();
    p0.req_valid = 1'b1;
    p1.req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      op0 = rand_op();
      op1 = rand_op();
      {p0.req_ctrl, p0.req_a, p0.req_b} = op0;
      {p1.req_ctrl, p1.req_a, p1.req_b} = op1;
      #1;
      got = 1'b0;
      for (int t = 0; t < 8; t++) begin
        if (p0.req_ready || p1.req_ready) begin
          got = 1'b1;
          break;
        end
        tick();
      end
      checks++;
      if (!got) begin
        failures++;
        $display("[TB] FAIL contention_timeout: got no grant expected grant %0d", k);
        idle_inputs();
        return;
      end
      g_exp = exp_grant(1'b1, 1'b1);
      checks++;
      if ({p0.req_ready, p1.req_ready} !== (g_exp ? 2'b01 : 2'b10)) begin
        failures++;
        $display("[TB] FAIL contention_grant%0d: got %b expected %b", k, {p0.req_ready, p1.req_ready}, g_exp ? 2'b01 : 2'b10);
      end
      exp_ops    = g_exp ? op1 : op0;
      exp_rsp    = model_op(exp_ops);
      model_last = g_exp;
      tick();
      {p0.req_ctrl, p0.req_a, p0.req_b} = rand_op();
      {p1.req_ctrl, p1.req_a, p1.req_b} = rand_op();
      #1;
      checks++;
      if ({alu_ctrl, alu_a, alu_b} !== exp_ops) begin
        failures++;
        $display("[TB] FAIL contention_issue_ops: got %h expected %h", {alu_ctrl, alu_a, alu_b}, exp_ops);
      end
      checks++;
      if ({p0.req_ready, p1.req_ready} !== 2'b00) begin
        failures++;
        $display("[TB] FAIL contention_busy_ready: got %b expected 00", {p0.req_ready, p1.req_ready});
      end
      tick();
      hold = $urandom_range(0, 3);
      for (int h = 0; h <= hold; h++) begin
        got_rsp = g_exp ? {p1.rsp_carry, p1.rsp_zero, p1.rsp_data} : {p0.rsp_carry, p0.rsp_zero, p0.rsp_data};
        checks++;
        if ({p0.rsp_valid, p1.rsp_valid} !== (g_exp ? 2'b01 : 2'b10)) begin
          failures++;
          $display("[TB] FAIL contention_rsp_valid: got %b expected %b", {p0.rsp_valid, p1.rsp_valid}, g_exp ? 2'b01 : 2'b10);
        end
        checks++;
        if (got_rsp !== exp_rsp) begin
          failures++;
          $display("[TB] FAIL contention_rsp_data: got %h expected %h", got_rsp, exp_rsp);
        end
        if (h == hold) begin
          if (g_exp) p1.rsp_ready = 1'b1;
          else       p0.rsp_ready = 1'b1;
        end
        tick();
      end
      p0.rsp_ready = 1'b0;
      p1.rsp_ready = 1'b0;
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q [$];
    int         acc_cyc [$];
    int         rsp_cyc [$];
    logic [7:0] exp_rsp;
    bit         accepted;
    p0.req_valid = 1'b1;
    p0.rsp_ready = 1'b1;
    {p0.req_ctrl, p0.req_a, p0.req_b} = rand_op();
    #1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      accepted = 1'b0;
      if (p0.rsp_valid) begin
        rsp_cyc.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL b2b_unexpected_rsp: got response at cycle %0d expected none", cyc);
        end else begin
          exp_rsp = exp_q.pop_front();
          if ({p0.rsp_carry, p0.rsp_zero, p0.rsp_data} !== exp_rsp) begin
            failures++;
            $display("[TB] FAIL b2b_rsp_data: got %h expected %h", {p0.rsp_carry, p0.rsp_zero, p0.rsp_data}, exp_rsp);
          end
        end
      end
      if (p0.req_ready) begin
        acc_cyc.push_back(cyc);
        exp_q.push_back(alu_model(p0.req_ctrl, p0.req_a, p0.req_b));
        accepted = 1'b1;
      end
      tick();
      if (accepted) {p0.req_ctrl, p0.req_a, p0.req_b} = rand_op();
      #1;
    end
    model_last = 1'b0;
    idle_inputs();
    checks++;
    if (acc_cyc.size() != 10 || rsp_cyc.size() != 10) begin
      failures++;
      $display("[TB] FAIL b2b_counts: got %0d accepts/%0d responses expected 10/10", acc_cyc.size(), rsp_cyc.size());
    end
    for (int i = 0; i + 1 < acc_cyc.size(); i++) begin
      checks++;
      if (acc_cyc[i+1] - acc_cyc[i] != 3) begin
        failures++;
        $display("[TB] FAIL b2b_spacing: got %0d expected 3", acc_cyc[i+1] - acc_cyc[i]);
      end
    end
    for (int i = 0; i < acc_cyc.size() && i < rsp_cyc.size(); i++) begin
      checks++;
      if (rsp_cyc[i] != acc_cyc[i] + 2) begin
        failures++;
        $display("[TB] FAIL b2b_latency: got cycle %0d expected %0d", rsp_cyc[i], acc_cyc[i] + 2);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] op0;
    p0.rsp_ready = 1'b1;
    p1.req_valid = 1'b1;
    {p1.req_ctrl, p1.req_a, p1.req_b} = {4'b0000, 6'h2A, 6'h15};
    #1;
    checks++;
    if ({p0.req_ready, p1.req_ready} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL bp_grant1: got %b expected 01", {p0.req_ready, p1.req_ready});
    end
    model_last = 1'b1;
    tick();
    p1.req_valid = 1'b0;
    op0 = rand_op();
    p0.req_valid = 1'b1;
    {p0.req_ctrl, p0.req_a, p0.req_b} = op0;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({p1.rsp_valid, p1.rsp_carry, p1.rsp_zero, p1.rsp_data} !== {1'b1, 1'b0, 1'b1, 6'd0}) begin
        failures++;
        $display("[TB] FAIL bp_hold%0d: got %h expected %h", i, {p1.rsp_valid, p1.rsp_carry, p1.rsp_zero, p1.rsp_data}, {1'b1, 1'b0, 1'b1, 6'd0});
      end
      checks++;
      if ({p0.req_ready, p0.rsp_valid} !== 2'b00) begin
        failures++;
        $display("[TB] FAIL bp_req0_blocked%0d: got %b expected 00", i, {p0.req_ready, p0.rsp_valid});
      end
      tick();
    end
    p1.rsp_ready = 1'b1;
    #1;
    checks++;
    if (p0.req_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_ready_before_hs: got %b expected 0", p0.req_ready);
    end
    tick();
    p1.rsp_ready = 1'b0;
    #1;
    checks++;
    if ({p0.req_ready, p1.rsp_valid} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL bp_ready_after_hs: got %b expected 10", {p0.req_ready, p1.rsp_valid});
    end
    model_last = 1'b0;
    tick();
    p0.req_valid = 1'b0;
    tick();
    checks++;
    if ({p0.rsp_valid, p0.rsp_carry, p0.rsp_zero, p0.rsp_data} !== {1'b1, model_op(op0)}) begin
      failures++;
      $display("[TB] FAIL bp_req0_rsp: got %h expected %h", {p0.rsp_valid, p0.rsp_carry, p0.rsp_zero, p0.rsp_data}, {1'b1, model_op(op0)});
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid_op();
    logic [15:0] op1;
    p0.req_valid = 1'b1;
    {p0.req_ctrl, p0.req_a, p0.req_b} = rand_op();
    tick();
    p0.req_valid = 1'b0;
    tick();
    checks++;
    if (p0.rsp_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midrst_pre_valid: got %b expected 1", p0.rsp_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({p0.rsp_valid, alu_ctrl, alu_a, alu_b} !== 17'h0) begin
      failures++;
      $display("[TB] FAIL midrst_clear: got %h expected 0", {p0.rsp_valid, alu_ctrl, alu_a, alu_b});
    end
    checks++;
    if ({p0.rsp_carry, p0.rsp_zero, p0.rsp_data} !== 8'h0) begin
      failures++;
      $display("[TB] FAIL midrst_rsp0_fields: got %h expected 00", {p0.rsp_carry, p0.rsp_zero, p0.rsp_data});
    end
    @(negedge clk);
    rst = 1'b0;
    model_last = 1'b1;
    tick();
    op1 = rand_op();
    p1.req_valid = 1'b1;
    {p1.req_ctrl, p1.req_a, p1.req_b} = op1;
    #1;
    checks++;
    if ({p0.req_ready, p1.req_ready} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL midrst_grant1: got %b expected 01", {p0.req_ready, p1.req_ready});
    end
    tick();
    p1.req_valid = 1'b0;
    checks++;
    if ({p0.rsp_valid, p1.rsp_valid} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL midrst_issue_valid: got %b expected 00", {p0.rsp_valid, p1.rsp_valid});
    end
    tick();
    checks++;
    if ({p0.rsp_valid, p1.rsp_valid, p1.rsp_carry, p1.rsp_zero, p1.rsp_data} !== {2'b01, model_op(op1)}) begin
      failures++;
      $display("[TB] FAIL midrst_rsp1: got %h expected %h", {p0.rsp_valid, p1.rsp_valid, p1.rsp_carry, p1.rsp_zero, p1.rsp_data}, {2'b01, model_op(op1)});
    end
    p1.rsp_ready = 1'b1;
    tick();
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    model_last = 1'b1;
    idle_inputs();
    test_reset();
    test_single_op();
    test_contention();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
